// File: rtl/multicycle_alu.sv
// Registered ALU with start/busy/done handshake; MULU and DIVU iterate one bit per clock
// and return a double-width result on result (low/quotient) and result_hi (high/remainder).
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_SUB  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_XNOR = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_MULU = 4'b1110;
    localparam logic [3:0] OP_DIVU = 4'b1111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             done_q, done_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH:0]   mul_sum, div_shl, div_diff;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;

    assign shamt = alu_in1[SHW-1:0];

    always_comb begin
        sc_res = '0;
        case (alu_sel)
            OP_ADD:  sc_res = alu_in1 + alu_in2;
            OP_SUB:  sc_res = alu_in1 - alu_in2;
            OP_SLL:  sc_res = alu_in2 << shamt;
            OP_SRL:  sc_res = alu_in2 >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(alu_in2) >>> shamt);
            OP_AND:  sc_res = alu_in1 & alu_in2;
            OP_OR:   sc_res = alu_in1 | alu_in2;
            OP_XOR:  sc_res = alu_in1 ^ alu_in2;
            OP_XNOR: sc_res = ~(alu_in1 ^ alu_in2);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(alu_in1) < $signed(alu_in2)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, alu_in1 < alu_in2};
            default: sc_res = '0;
        endcase
    end

    // hi:lo holds partial product (MULU) or remainder:quotient (DIVU); opnd is multiplicand/divisor.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi   = mul_sum[WIDTH:1];
        mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_shl  = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_shl - {1'b0, opnd_q};
        div_hi   = div_diff[WIDTH] ? div_shl[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_lo   = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        div_d       = div_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (alu_sel == OP_MULU || alu_sel == OP_DIVU) begin
                        state_d = RUN;
                        cnt_d   = CW'(WIDTH);
                        div_d   = (alu_sel == OP_DIVU);
                        hi_d    = '0;
                        lo_d    = (alu_sel == OP_DIVU) ? alu_in1 : alu_in2;
                        opnd_d  = (alu_sel == OP_DIVU) ? alu_in2 : alu_in1;
                    end else begin
                        result_d    = sc_res;
                        result_hi_d = '0;
                        done_d      = 1'b1;
                    end
                end
            end
            RUN: begin
                hi_d  = div_q ? div_hi : mul_hi;
                lo_d  = div_q ? div_lo : mul_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = IDLE;
                    result_d    = lo_d;
                    result_hi_d = hi_d;
                    done_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            div_q       <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            div_q       <= div_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = (result_q == '0);
endmodule
